coin_frontend: RTL
==================

Name: coin_frontend

Overview:
Front-end stage that directly feeds the vending accumulator. It takes the three raw, bouncy coin-sensor lines and synchronises and debounces each one. It converts each accepted insertion into a single queued coin event, then emits events one per cycle as one-hot, single-cycle nickel/dime/quarter pulses. A small FIFO absorbs bursts and simultaneous insertions. Coins that cannot be queued are flagged on reject, which drives the coin-return chute.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised input must differ from its debounced state before the debounced state flips (min 2)
FIFO_DEPTH, 4, coin-event queue entries (power of 2, min 2)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
nickel_raw  input  1  raw nickel sensor, asynchronous, bouncy, high while coin present
dime_raw  input  1  raw dime sensor, same properties
quarter_raw  input  1  raw quarter sensor, same properties
accept_en  input  1  downstream may take a coin event this cycle
nickel  output  1  one-cycle pulse, one nickel delivered
dime  output  1  one-cycle pulse, one dime delivered
quarter  output  1  one-cycle pulse, one quarter delivered
reject  output  1  one-cycle pulse, at least one coin dropped this cycle
fifo_count  output  $clog2(FIFO_DEPTH+1)  queued events

Behaviour:
- Clock and reset: clk is the clock; reset_n is asynchronous, active-low.
- Reset values:
  - sync flops, debounced states, debounce counters: 0
  - FIFO: empty
  - nickel/dime/quarter/reject: 0
  - fifo_count: 0
- Synchronisation: each raw input passes through a 2-flop synchroniser.
- Debounce, per channel: counter cnt of width $clog2(DEBOUNCE_CYCLES); debounced state stb.
  - If sync == stb: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: stb <= sync, cnt <= 0.
  - Else: cnt <= cnt+1.
- Coin event: generated in the cycle stb is updated 0->1. The 1->0 transition generates nothing. A glitch shorter than DEBOUNCE_CYCLES cycles produces no event.
- Enqueue:
  - Events detected at the same edge are pushed in fixed order nickel, dime, quarter; up to 3 pushes per cycle.
  - Free slots = FIFO_DEPTH - fifo_count + (pop this cycle ? 1 : 0).
  - Events beyond the free slots are dropped in reverse order (quarter first), and reject <= 1 for the next cycle.
- Dequeue:
  - At each edge where accept_en=1 and the FIFO is non-empty, pop the head and register its one-hot decode onto nickel/dime/quarter.
  - Otherwise the outputs register 0.
  - At most one output is high in any cycle.
  - Back-to-back pulses on consecutive cycles are permitted.
  - accept_en=0 holds the queue; no events are lost while the queue has room.
- Latency: raw high sampled at edge 1 → sync high after edge 2 → stb high and event pushed at edge 2+DEBOUNCE_CYCLES → pulse high for the one cycle after edge 3+DEBOUNCE_CYCLES. This assumes accept_en=1 and an empty FIFO.
- fifo_count: registered; updated at the same edge as push/pop; never exceeds FIFO_DEPTH.
- FIFO storage: 2-bit coin code per entry (01 nickel, 10 dime, 11 quarter) with wrapping read/write pointers.
- Reset mid-operation: all queued and in-flight events are discarded and outputs drop immediately. A raw line held high through reset is seen as a fresh rise after reset release and yields exactly one event.

Test Plan:
- DEBOUNCE_CYCLES=4, accept_en=1, dime_raw held high 10 cycles → exactly one dime pulse, in the cycle after edge 7; fifo_count peaks at 1.
- DEBOUNCE_CYCLES=4, quarter_raw toggling every 2 cycles for 20 cycles, then low → no pulses, reject=0.
- accept_en=0; insert nickel, dime, quarter sequentially (separate debounced presses) → fifo_count=3. Then raise accept_en → pulses nickel, dime, quarter on 3 consecutive cycles; fifo_count 3,2,1,0.
- FIFO_DEPTH=4, accept_en=0, fifo_count=3; all three raws debounce-rise on the same edge → nickel queued; dime and quarter dropped; reject high one cycle; fifo_count=4.
- FIFO full, accept_en=1; one nickel event on the same edge as a pop → no reject; fifo_count stays 4.
- Assert reset_n low while fifo_count=2 and quarter_raw is high → outputs and fifo_count 0 immediately. After release with quarter_raw still high → exactly one quarter pulse, DEBOUNCE_CYCLES+3 edges later.

Source files
------------

// File: rtl/coin_frontend_if.sv
// Coin front-end bus: raw sensor lines and the downstream handshake in,
// one-hot coin pulses, reject flag and queue occupancy out.
interface coin_frontend_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic          nickel_raw;
   logic          dime_raw;
   logic          quarter_raw;
   logic          accept_en;
   logic          nickel;
   logic          dime;
   logic          quarter;
   logic          reject;
   logic [CW-1:0] fifo_count;

   // The coin front-end itself
   modport master (
      input  nickel_raw, dime_raw, quarter_raw, accept_en,
      output nickel, dime, quarter, reject, fifo_count
   );

   // Sensor side / downstream accumulator
   modport slave (
      output nickel_raw, dime_raw, quarter_raw, accept_en,
      input  nickel, dime, quarter, reject, fifo_count
   );
endinterface

// File: rtl/coin_frontend.sv
// Coin front-end: synchronises and debounces three coin sensors, turns each
// debounced rising edge into a queued coin event, and delivers queued events
// as single-cycle one-hot pulses when the downstream accepts them. Coins that
// find no room in the queue are dropped and flagged on reject.
module coin_frontend #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   coin_frontend_if.master  bus
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CW    = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Channel order everywhere: bit 0 nickel, bit 1 dime, bit 2 quarter
   logic [2:0] raw;
   logic [2:0] sync1_q, sync1_d;
   logic [2:0] sync2_q, sync2_d;
   logic [2:0] evt;

   assign raw = {bus.quarter_raw, bus.dime_raw, bus.nickel_raw};

   // Two-stage synchroniser next-state for the asynchronous sensor lines
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
   end

   // Synchroniser flops
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_deb
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             stb_q, stb_d;

         // Debounce: the stable state flips only after the synchronised
         // input has disagreed with it for DEBOUNCE_CYCLES straight cycles
         always_comb begin
            cnt_d = cnt_q;
            stb_d = stb_q;
            if (sync2_q[gi] == stb_q) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_MAX) begin
               stb_d = sync2_q[gi];
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // Debounce state flops
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               cnt_q <= '0;
               stb_q <= 1'b0;
            end else begin
               cnt_q <= cnt_d;
               stb_q <= stb_d;
            end
         end

         // A coin event is the edge at which the stable state rises
         assign evt[gi] = stb_d & ~stb_q;
      end
   endgenerate

   logic [1:0]       mem_q [FIFO_DEPTH];
   logic [1:0]       mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             nickel_q, nickel_d;
   logic             dime_q, dime_d;
   logic             quarter_q, quarter_d;
   logic             reject_q, reject_d;
   logic             pop;
   logic [CW-1:0]    free_slots;
   logic [1:0]       n_push;
   logic [1:0]       head;

   // Queue control: pop first so its slot can be reused by this edge's pushes,
   // then push events nickel->dime->quarter; whatever does not fit is dropped
   always_comb begin
      mem_d      = mem_q;
      pop        = bus.accept_en && (count_q != '0);
      free_slots = CW'(FIFO_DEPTH) - count_q + CW'(pop);
      n_push     = '0;
      reject_d   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (evt[k]) begin
            if (CW'(n_push) < free_slots) begin
               mem_d[wr_ptr_q + PTR_W'(n_push)] = 2'(k + 1);
               n_push = n_push + 2'd1;
            end else begin
               reject_d = 1'b1;
            end
         end
      end
      wr_ptr_d  = wr_ptr_q + PTR_W'(n_push);
      rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
      count_d   = count_q - CW'(pop) + CW'(n_push);
      head      = mem_q[rd_ptr_q];
      nickel_d  = pop && (head == 2'b01);
      dime_d    = pop && (head == 2'b10);
      quarter_d = pop && (head == 2'b11);
   end

   // Queue storage; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Queue pointers, occupancy and registered output pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         nickel_q  <= 1'b0;
         dime_q    <= 1'b0;
         quarter_q <= 1'b0;
         reject_q  <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         nickel_q  <= nickel_d;
         dime_q    <= dime_d;
         quarter_q <= quarter_d;
         reject_q  <= reject_d;
      end
   end

   assign bus.nickel     = nickel_q;
   assign bus.dime       = dime_q;
   assign bus.quarter    = quarter_q;
   assign bus.reject     = reject_q;
   assign bus.fifo_count = count_q;
endmodule
